// File: rtl/serial_pkg.sv
// Shared state encoding, default bit-rate constants and counter sizing helper for the serial transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_HALF_DIV = 25;  // 25 MHz clock / 50 = 500 kHz bit rate

  // Counter width for a counter that wraps after reaching terminal-1; never below one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Half-period tick generator: tick pulses every HALF_DIV cycles while run=1, counter parked at 0 otherwise.
// Latency: first tick HALF_DIV cycles after run rises; no backpressure.
import serial_pkg::*;

module sclk_divider #(
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int            CW   = cnt_width(HALF_DIV);
  localparam logic [CW-1:0] TERM = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == TERM);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx_shifter.sv
// MSB-first serial transmitter with sclk/latch strobe; frame = bits*2*HALF_DIV + 2*HALF_DIV cycles, accepts only in IDLE.
// Optional even-parity bit after the LSB when SERIAL_PARITY_EN is defined; in_valid outside IDLE is dropped, not queued.
import serial_pkg::*;

module serial_tx_shifter #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            BW       = cnt_width(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             phase;
  logic             tick;
  logic             period_end;
  logic             done_q;

  sclk_divider #(.HALF_DIV(HALF_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // phase=1 marks the sclk-high half, so a tick there closes the whole bit period
  assign period_end = tick && phase;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                             state_nxt = SHIFT;
      SHIFT:   if (period_end && (bit_cnt == LAST_BIT))  state_nxt = LATCH;
      LATCH:   if (period_end)                           state_nxt = IDLE;
      default:                                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == LATCH) && period_end;
      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (in_valid) begin
`ifdef SERIAL_PARITY_EN
            shreg <= {in_data, ^in_data};
`else
            shreg <= in_data;
`endif
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) phase <= ~phase;
          if (period_end) begin
            shreg   <= {shreg[NBITS-2:0], 1'b0};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
          end
        end
        LATCH: begin
          if (tick) phase <= ~phase;
        end
        default: phase <= 1'b0;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    sclk     = 1'b0;
    sdata    = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        busy  = 1'b1;
        sclk  = phase;
        sdata = shreg[NBITS-1];
      end
      LATCH: begin
        busy  = 1'b1;
        latch = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: HALF_DIV=2 instance with a bit scoreboard and pin monitor, plus a HALF_DIV=1 instance.
module tb_serial_tx_shifter;

  localparam int W  = 16;
  localparam int HD = 2;
`ifdef SERIAL_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int FRAME  = NB * 2 * HD + 2 * HD;
  localparam int FRAME1 = NB * 2 + 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data, in_data1;
  logic         in_valid, in_valid1;
  logic         in_ready, sdata, sclk, latch, busy, done;
  logic         in_ready1, sdata1, sclk1, latch1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  bit q[$];
  bit q1[$];

  bit   mon_en = 1'b0;
  logic prev_sclk = 1'b0, prev_sdata = 1'b0, prev_busy = 1'b0, prev_latch = 1'b0;
  int   busy_run = 0, idle_run = 0, last_busy_len = 0, last_idle_len = 0;
  int   latch_run = 0, last_latch_len = 0, latch_total = 0, done_cnt = 0, bits_seen = 0;

  always #5 clock = ~clock;

  serial_tx_shifter #(.WIDTH(W), .HALF_DIV(HD)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sdata(sdata), .sclk(sclk), .latch(latch), .busy(busy), .done(done)
  );

  serial_tx_shifter #(.WIDTH(W), .HALF_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sdata(sdata1), .sclk(sclk1), .latch(latch1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit to_u1);
    for (int i = W - 1; i >= 0; i--) begin
      if (to_u1) q1.push_back(w[i]);
      else       q.push_back(w[i]);
    end
`ifdef SERIAL_PARITY_EN
    if (to_u1) q1.push_back(^w);
    else       q.push_back(^w);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check("ready_seen", in_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] w);
    wait_ready();
    in_data  = w;
    in_valid = 1'b1;
    push_word(w, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check(tag, done, 1);
  endtask

  // Pin monitor: bit scoreboard at sclk rising edges, pin-level rules, and run-length bookkeeping.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (sclk && !prev_sclk) begin
          bits_seen++;
          check("bit_expected", (q.size() > 0), 1);
          if (q.size() > 0) check("bit_value", sdata, q.pop_front());
        end
        if (sclk && prev_sclk) check("sdata_stable_sclk_high", sdata, prev_sdata);
        if (!busy)  check("idle_pins_low", {sclk, sdata, latch}, 3'b000);
        if (latch)  check("latch_pins_low", {sclk, sdata}, 2'b00);
        if (busy && !prev_busy) begin
          last_idle_len = idle_run;
          busy_run = 1;
        end else if (busy) begin
          busy_run++;
        end
        if (!busy && prev_busy) begin
          last_busy_len = busy_run;
          idle_run = 1;
        end else if (!busy) begin
          idle_run++;
        end
        if (latch) begin
          latch_total++;
          if (!prev_latch) latch_run = 1;
          else             latch_run++;
        end
        if (!latch && prev_latch) last_latch_len = latch_run;
        if (done) done_cnt++;
      end
      prev_sclk  = sclk;
      prev_sdata = sdata;
      prev_busy  = busy;
      prev_latch = latch;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, l0, n, mism, busy_cnt;
    bit p1, first;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sdata", sdata, 0);
    check("rst_sclk", sclk, 0);
    check("rst_latch", latch, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready_hd1", in_ready1, 1);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Single frame A5C3
    d0 = done_cnt;
    send(16'hA5C3);
    check("a5c3_busy_after_accept", busy, 1);
    wait_done("a5c3_done_seen");
    check("a5c3_ready_in_done_cycle", in_ready, 1);
    @(posedge clock); #1;
    check("a5c3_busy_len", last_busy_len, FRAME);
    check("a5c3_latch_len", last_latch_len, 2 * HD);
    check("a5c3_done_count", done_cnt - d0, 1);
    check("a5c3_done_one_cycle", done, 0);
    check("a5c3_all_bits_sent", q.size(), 0);

    // Back-to-back with in_valid held high
    in_data  = 16'h0001;
    in_valid = 1'b1;
    push_word(16'h0001, 1'b0);
    push_word(16'hFFFF, 1'b0);
    @(posedge clock); #1;
    check("b2b_first_accept", busy, 1);
    in_data = 16'hFFFF;
    wait_done("b2b_first_done_seen");
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("b2b_second_accept", busy, 1);
    check("b2b_first_busy_len", last_busy_len, FRAME);
    wait_done("b2b_second_done_seen");
    @(posedge clock); #1;
    check("b2b_extra_gap", last_idle_len - 1, 0);
    check("b2b_second_busy_len", last_busy_len, FRAME);
    check("b2b_all_bits_sent", q.size(), 0);

    // in_valid during SHIFT is ignored
    d0 = done_cnt;
    send(16'h00F0);
    repeat (10) begin @(posedge clock); #1; end
    in_data  = 16'h1234;
    in_valid = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    wait_done("ign_done_seen");
    @(posedge clock); #1;
    check("ign_all_bits_sent", q.size(), 0);
    check("ign_done_count", done_cnt - d0, 1);
    repeat (3) begin @(posedge clock); #1; end
    check("ign_no_second_frame", busy, 0);

    // Reset mid-frame at bit 7
    b0 = bits_seen;
    d0 = done_cnt;
    l0 = latch_total;
    send(16'hFFFF);
    n = 0;
    while ((bits_seen - b0) < 7 && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check("abort_bit7_reached", bits_seen - b0, 7);
    reset = 1'b0;
    q.delete();
    @(posedge clock); #1;
    check("abort_sclk", sclk, 0);
    check("abort_sdata", sdata, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_latch", latch, 0);
    check("abort_done", done, 0);
    reset = 1'b1;
    repeat (20) begin @(posedge clock); #1; end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_latch", latch_total - l0, 0);

    // HALF_DIV=1 instance
    check("hd1_ready", in_ready1, 1);
    in_data1  = 16'h8000;
    in_valid1 = 1'b1;
    push_word(16'h8000, 1'b1);
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    mism     = 0;
    busy_cnt = 0;
    p1       = 1'b0;
    first    = 1'b1;
    for (int k = 0; k < FRAME1 + 6; k++) begin
      if (busy1) busy_cnt++;
      if (k < NB * 2 && sclk1 !== 1'(k % 2)) mism++;
      if (sclk1 && !p1) begin
        if (first) check("hd1_first_bit", sdata1, 1);
        first = 1'b0;
        check("hd1_bit_expected", (q1.size() > 0), 1);
        if (q1.size() > 0) check("hd1_bit_value", sdata1, q1.pop_front());
      end
      p1 = sclk1;
      @(posedge clock); #1;
    end
    check("hd1_sclk_toggle_mismatches", mism, 0);
    check("hd1_busy_len", busy_cnt, FRAME1);
    check("hd1_all_bits_sent", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
